// File: rtl/uart_boot_loader.sv
// ============================================================================
// Module   : uart_boot_loader
// Purpose  : Parses framed UART download packets into 32-bit RAM writes,
//            halts the CPU during a download, and returns a one-byte ack.
//            Optional inter-byte timeout: define UART_LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_boot_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_OK         = 8'h5A,
  parameter logic [7:0]  ACK_ERR        = 8'hEE,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [7:0]  tx_byte_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        halt_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_csum;
  logic [23:0] r_word;
  logic        r_err_pend;
`ifdef UART_LOADER_TIMEOUT_EN
  logic [31:0] r_tmo;
`endif

  logic [7:0]  w_csum_next;
  logic        w_last_word;
  logic [15:0] w_len_full;

  assign w_csum_next = r_csum + rx_byte_i;
  assign w_last_word = (r_word_cnt == r_len - 16'd1);
  assign w_len_full  = {rx_byte_i, r_len[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_csum      <= '0;
      r_word      <= '0;
      r_err_pend  <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      tx_byte_o   <= '0;
      tx_valid_o  <= 1'b0;
      halt_o      <= 1'b0;
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      mem_we_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid_i && rx_byte_i == SYNC_BYTE) begin
            r_csum      <= '0;
            r_byte_cnt  <= '0;
            r_word_cnt  <= '0;
            r_err_pend  <= 1'b0;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
            halt_o      <= 1'b1;
            r_state     <= S_ADDR;
`ifdef UART_LOADER_TIMEOUT_EN
            r_tmo       <= '0;
`endif
          end
        end
        S_ADDR: begin
          if (rx_valid_i) begin
            r_addr[{r_byte_cnt, 3'b000} +: 8] <= rx_byte_i;
            r_csum     <= w_csum_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Alignment bits live in the first (least significant) byte.
              if (r_addr[1:0] != 2'b00) r_err_pend <= 1'b1;
              r_state <= S_LEN;
            end
          end
        end
        S_LEN: begin
          if (rx_valid_i) begin
            r_csum <= w_csum_next;
            if (r_byte_cnt[0] == 1'b0) begin
              r_len[7:0] <= rx_byte_i;
              r_byte_cnt <= 2'd1;
            end else begin
              r_len[15:8] <= rx_byte_i;
              r_byte_cnt  <= 2'd0;
              r_word_cnt  <= '0;
              r_state     <= (w_len_full == 16'd0) ? S_CSUM : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_valid_i) begin
            r_csum     <= w_csum_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0:    r_word[7:0]   <= rx_byte_i;
              2'd1:    r_word[15:8]  <= rx_byte_i;
              2'd2:    r_word[23:16] <= rx_byte_i;
              default: begin
                if (!r_err_pend) begin
                  mem_we_o    <= 1'b1;
                  mem_addr_o  <= r_addr + {14'd0, r_word_cnt, 2'b00};
                  mem_wdata_o <= {rx_byte_i, r_word};
                end
                r_word_cnt <= r_word_cnt + 16'd1;
                if (w_last_word) r_state <= S_CSUM;
              end
            endcase
          end
        end
        S_CSUM: begin
          if (rx_valid_i) begin
            tx_valid_o <= 1'b1;
            r_state    <= S_RESP;
            if (rx_byte_i == r_csum && !r_err_pend) begin
              tx_byte_o   <= ACK_OK;
              load_done_o <= 1'b1;
            end else begin
              tx_byte_o  <= ACK_ERR;
              load_err_o <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            halt_o     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

`ifdef UART_LOADER_TIMEOUT_EN
      // Placed after the case so an expiry overrides the idle-state hold.
      if (r_state inside {S_ADDR, S_LEN, S_DATA, S_CSUM}) begin
        if (rx_valid_i) begin
          r_tmo <= '0;
        end else if (r_tmo == TIMEOUT_CYCLES - 32'd1) begin
          r_tmo      <= '0;
          r_state    <= S_RESP;
          tx_byte_o  <= ACK_ERR;
          tx_valid_o <= 1'b1;
          load_err_o <= 1'b1;
        end else begin
          r_tmo <= r_tmo + 32'd1;
        end
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
// ============================================================================
// Module   : tb_uart_boot_loader
// Purpose  : Self-checking bench for uart_boot_loader (table + random packets).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_boot_loader;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam logic [31:0] c_TMO = 32'd100;
`else
  localparam logic [31:0] c_TMO = 32'd500000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [7:0]  tx_byte_o;
  logic        tx_valid_o;
  logic        halt_o;
  logic        load_done_o;
  logic        load_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wr_q[$];

  typedef struct {
    logic [31:0] addr;
    int          len;
    bit          bad;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  exp_ack;
    int          exp_nwr;
  } vec_t;

  always #5 clk = ~clk;

  uart_boot_loader #(.TIMEOUT_CYCLES(c_TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte_i   (rx_byte),
    .rx_valid_i  (rx_valid),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .tx_byte_o   (tx_byte_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready),
    .halt_o      (halt_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o)
  );

  always @(negedge clk) begin
    if (mem_we_o) wr_q.push_back('{mem_addr_o, mem_wdata_o});
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic put_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] model_ack(input logic [31:0] addr, input bit bad);
    return (addr[1:0] == 2'b00 && !bad) ? 8'h5A : 8'hEE;
  endfunction

  task automatic run_packet(input logic [31:0] addr, input int len, input logic [31:0] words[$],
                            input bit bad, input logic [7:0] exp_ack, input int exp_nwr,
                            input int ready_delay);
    logic [7:0] bytes[$];
    logic [7:0] sum, b, held;
    logic [15:0] l16;
    bit stable;
    int n;
    l16 = 16'(len);
    bytes = {addr[7:0], addr[15:8], addr[23:16], addr[31:24], l16[7:0], l16[15:8]};
    foreach (words[i])
      bytes = {bytes, words[i][7:0], words[i][15:8], words[i][23:16], words[i][31:24]};
    sum = 8'h00;
    foreach (bytes[i]) sum = sum + bytes[i];
    if (bad) sum = sum + 8'd1;
    wr_q.delete();

    repeat ($urandom_range(0, 2)) begin
      b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      put_byte(b);
    end
    put_byte(8'hA5);
    @(negedge clk);
    check("halt_after_sync", {94'd0, halt_o}, 96'd1);
    check("flags_cleared", {94'd0, load_done_o, load_err_o}, 96'd0);
    @(posedge clk); #1;
    foreach (bytes[i]) begin
      put_byte(bytes[i]);
      idle($urandom_range(0, 2));
    end
    put_byte(sum);

    n = 0;
    while (!tx_valid_o && n < 50) begin @(negedge clk); n++; end
    check("resp_valid", {95'd0, tx_valid_o}, 96'd1);
    check("resp_byte", {88'd0, tx_byte_o}, {88'd0, exp_ack});
    check("resp_flags", {93'd0, halt_o, load_done_o, load_err_o},
          {93'd0, 1'b1, exp_ack == 8'h5A, exp_ack != 8'h5A});
    held = tx_byte_o;
    stable = 1'b1;
    repeat (ready_delay) begin
      @(negedge clk);
      if (tx_byte_o !== held || tx_valid_o !== 1'b1) stable = 1'b0;
    end
    check("resp_stable", {95'd0, stable}, 96'd1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("resp_exit", {94'd0, tx_valid_o, halt_o}, 96'd0);

    check("write_count", 96'(wr_q.size()), 96'(exp_nwr));
    for (int i = 0; i < exp_nwr && i < wr_q.size(); i++) begin
      check("write_addr", {64'd0, wr_q[i].addr}, {64'd0, addr + 32'(4 * i)});
      check("write_data", {64'd0, wr_q[i].data}, {64'd0, words[i]});
    end
  endtask

  initial begin
    vec_t tbl[5];
    logic [31:0] words[$];
    logic [31:0] a;
    logic [7:0] held;
    bit stable;
    int len, n;
    bit bad;

    tbl[0] = '{32'h0000_1000, 2, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 8'h5A, 2};
    tbl[1] = '{32'h0000_1000, 2, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 8'hEE, 2};
    tbl[2] = '{32'h0000_1002, 1, 1'b0, 32'hCAFE_F00D, 32'h0,         8'hEE, 0};
    tbl[3] = '{32'h0000_2000, 0, 1'b0, 32'h0,         32'h0,         8'h5A, 0};
    tbl[4] = '{32'hFFFF_FFFC, 2, 1'b0, 32'hA1B2_C3D4, 32'h0102_0304, 8'h5A, 2};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a", {63'd0, mem_we_o, mem_addr_o}, 96'd0);
    check("reset_outputs_b", {52'd0, mem_wdata_o, tx_byte_o, tx_valid_o, halt_o,
                              load_done_o, load_err_o}, 96'd0);
    rst_n = 1'b1;
    idle(2);

    foreach (tbl[k]) begin
      words.delete();
      if (tbl[k].len > 0) words.push_back(tbl[k].w0);
      if (tbl[k].len > 1) words.push_back(tbl[k].w1);
      run_packet(tbl[k].addr, tbl[k].len, words, tbl[k].bad, tbl[k].exp_ack,
                 tbl[k].exp_nwr, $urandom_range(0, 3));
    end

    for (int it = 0; it < 20; it++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      len = $urandom_range(0, 5);
      bad = ($urandom_range(0, 3) == 0);
      words.delete();
      for (int i = 0; i < len; i++) words.push_back($urandom);
      run_packet(a, len, words, bad, model_ack(a, bad),
                 (a[1:0] == 2'b00) ? len : 0, $urandom_range(0, 4));
    end

    // Exact latencies, stalled response and dropped bytes during RESP.
    wr_q.delete();
    put_byte(8'hA5);
    put_byte(8'h00); put_byte(8'h01); put_byte(8'h00); put_byte(8'h00);
    put_byte(8'h01); put_byte(8'h00);
    put_byte(8'h44); put_byte(8'h33); put_byte(8'h22); put_byte(8'h11);
    @(negedge clk);
    check("we_latency", {31'd0, mem_we_o, mem_addr_o, mem_wdata_o},
          {31'd0, 1'b1, 32'h0000_0100, 32'h1122_3344});
    @(negedge clk);
    check("we_single_pulse", {95'd0, mem_we_o}, 96'd0);
    @(posedge clk); #1;
    put_byte(8'hAC);
    @(negedge clk);
    check("csum_to_tx_latency", {87'd0, tx_valid_o, tx_byte_o}, {87'd0, 1'b1, 8'h5A});
    held = tx_byte_o;
    stable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      put_byte((i == 0) ? 8'hA5 : 8'($urandom));
      idle(1);
      if (tx_valid_o !== 1'b1 || tx_byte_o !== held) stable = 1'b0;
    end
    check("stall_stable", {95'd0, stable}, 96'd1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("stall_exit", {94'd0, tx_valid_o, halt_o}, 96'd0);
    idle(3);
    check("resp_bytes_dropped", {94'd0, halt_o, tx_valid_o}, 96'd0);
    check("stall_writes", 96'(wr_q.size()), 96'd1);

    // Reset in the middle of a data word.
    wr_q.delete();
    put_byte(8'hA5);
    put_byte(8'h00); put_byte(8'h04); put_byte(8'h00); put_byte(8'h00);
    put_byte(8'h01); put_byte(8'h00);
    put_byte(8'h55); put_byte(8'h66);
    check("halt_mid_data", {95'd0, halt_o}, 96'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", {90'd0, mem_we_o, tx_valid_o, halt_o, load_done_o,
                                 load_err_o, |tx_byte_o}, 96'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    put_byte(8'h77); put_byte(8'h11);
    idle(3);
    check("no_write_after_abort", 96'(wr_q.size()), 96'd0);
    check("idle_after_abort", {94'd0, halt_o, tx_valid_o}, 96'd0);

`ifdef UART_LOADER_TIMEOUT_EN
    wr_q.delete();
    put_byte(8'hA5);
    put_byte(8'h00); put_byte(8'h30); put_byte(8'h00); put_byte(8'h00);
    put_byte(8'h01); put_byte(8'h00);
    put_byte(8'h12); put_byte(8'h34);
    n = 0;
    while (!tx_valid_o && n < 300) begin @(negedge clk); n++; end
    check("timeout_fired", {95'd0, tx_valid_o}, 96'd1);
    check("timeout_window", {95'd0, (n >= 99 && n <= 102)}, 96'd1);
    check("timeout_ack", {86'd0, tx_byte_o, load_err_o, load_done_o},
          {86'd0, 8'hEE, 1'b1, 1'b0});
    check("timeout_no_write", 96'(wr_q.size()), 96'd0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("timeout_exit", {94'd0, tx_valid_o, halt_o}, 96'd0);
`else
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
